// File: rtl/decode_execute_pkg.sv
// decode_execute_pkg
//   Shared constants for the TinyRisc-V decode/execute stage:
//   - next-PC mux select width and codes, consumed by the downstream PC mux
//   - RV32I opcode and funct3 encodings
//   - ALU operation type used between the decoder and the alu sub-module
package decode_execute_pkg;

  localparam int DATA_W = 32;

  // Next-PC mux selects
  localparam int SEL_PC_WIDTH = 2;
  localparam logic [SEL_PC_WIDTH-1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [SEL_PC_WIDTH-1:0] PC_SEL_PCIMM = 2'd1;
  localparam logic [SEL_PC_WIDTH-1:0] PC_SEL_JALR  = 2'd2;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

endpackage

// File: rtl/decode_execute_alu.sv
// alu
//   Combinational RV32I integer ALU shared by OP and OP-IMM.
//   Ports:
//     op     - operation select (alu_op_e)
//     a, b   - operands; shifts use b[4:0] as the shift amount
//     result - 32-bit result, modulo 2^32
module alu
  import decode_execute_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [4:0]               shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = DATA_W'(a_s >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/decode_execute.sv
// decode_execute
//   Combined RV32I decode and execute stage. Decodes ir combinationally,
//   drives register-file read addresses in the same cycle, evaluates the
//   ALU / branch / jump behaviour on the returned operands and registers
//   every result on the next rising clock edge.
//   Ports:
//     clk, rst_n          - clock, asynchronous active-low reset
//     ir, pc              - instruction word and its address
//     rs1_data, rs2_data  - register-file read data (same cycle)
//     rs1_num, rs2_num    - register-file read addresses (combinational)
//     opcode, func3       - registered instruction fields
//     wb_reg, rd_num      - registered write enable and destination
//     rd_data             - registered result / effective address
//     imm                 - registered sign-extended immediate
//     pc_sel, br_taken    - registered next-PC select and redirect flag
module decode_execute
  import decode_execute_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             ir,
  input  logic [31:0]             pc,
  input  logic [31:0]             rs1_data,
  input  logic [31:0]             rs2_data,
  output logic [4:0]              rs1_num,
  output logic [4:0]              rs2_num,
  output logic [6:0]              opcode,
  output logic [2:0]              func3,
  output logic                    wb_reg,
  output logic [4:0]              rd_num,
  output logic [31:0]             rd_data,
  output logic [31:0]             imm,
  output logic [SEL_PC_WIDTH-1:0] pc_sel,
  output logic                    br_taken
);

  logic [6:0]  opc_p0;
  logic [2:0]  f3_p0;
  logic [4:0]  rd_p0;
  logic [31:0] imm_p0;
  logic [31:0] rd_data_p0;
  logic        wb_p0;
  logic        br_p0;
  logic [SEL_PC_WIDTH-1:0] pc_sel_p0;

  alu_op_e     alu_op_p0;
  logic [31:0] alu_b_p0;
  logic [31:0] alu_res_p0;

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;
  logic br_eq, br_lt, br_ltu, br_cond;

  assign rs1_num = ir[19:15];
  assign rs2_num = ir[24:20];
  assign opc_p0  = ir[6:0];
  assign f3_p0   = ir[14:12];
  assign rd_p0   = ir[11:7];

  assign rs1_s   = rs1_data;
  assign rs2_s   = rs2_data;
  assign br_eq   = (rs1_data == rs2_data);
  assign br_lt   = (rs1_s < rs2_s);
  assign br_ltu  = (rs1_data < rs2_data);

  // Immediate generation
  always_comb begin
    imm_p0 = '0;
    unique case (opc_p0)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_p0 = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:
        imm_p0 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:
        imm_p0 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_p0 = {ir[31:12], 12'b0};
      OPC_JAL:
        imm_p0 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm_p0 = '0;
    endcase
  end

  // ALU operation decode; OP-IMM has no SUBI, so ir[30] only matters for
  // the right shifts there. For shifts imm[4:0] equals ir[24:20].
  always_comb begin
    alu_op_p0 = ALU_ADD;
    alu_b_p0  = (opc_p0 == OPC_OP) ? rs2_data : imm_p0;
    unique case (f3_p0)
      F3_ADD:  alu_op_p0 = (opc_p0 == OPC_OP && ir[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op_p0 = ALU_SLL;
      F3_SLT:  alu_op_p0 = ALU_SLT;
      F3_SLTU: alu_op_p0 = ALU_SLTU;
      F3_XOR:  alu_op_p0 = ALU_XOR;
      F3_SR:   alu_op_p0 = ir[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op_p0 = ALU_OR;
      F3_AND:  alu_op_p0 = ALU_AND;
      default: alu_op_p0 = ALU_ADD;
    endcase
  end

  alu u_alu (
    .op     (alu_op_p0),
    .a      (rs1_data),
    .b      (alu_b_p0),
    .result (alu_res_p0)
  );

  always_comb begin
    br_cond = 1'b0;
    unique case (f3_p0)
      F3_BEQ:  br_cond = br_eq;
      F3_BNE:  br_cond = !br_eq;
      F3_BLT:  br_cond = br_lt;
      F3_BGE:  br_cond = !br_lt;
      F3_BLTU: br_cond = br_ltu;
      F3_BGEU: br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  // Result, write-enable and next-PC select
  always_comb begin
    rd_data_p0 = '0;
    wb_p0      = 1'b0;
    br_p0      = 1'b0;
    pc_sel_p0  = PC_SEL_PLUS4;
    unique case (opc_p0)
      OPC_OP, OPC_OP_IMM: begin
        rd_data_p0 = alu_res_p0;
        wb_p0      = 1'b1;
      end
      OPC_LOAD: begin
        rd_data_p0 = rs1_data + imm_p0;
        wb_p0      = 1'b1;
      end
      OPC_STORE: begin
        rd_data_p0 = rs1_data + imm_p0;
      end
      OPC_BRANCH: begin
        br_p0     = br_cond;
        pc_sel_p0 = br_cond ? PC_SEL_PCIMM : PC_SEL_PLUS4;
      end
      OPC_LUI: begin
        rd_data_p0 = imm_p0;
        wb_p0      = 1'b1;
      end
      OPC_AUIPC: begin
        rd_data_p0 = pc + imm_p0;
        wb_p0      = 1'b1;
      end
      OPC_JAL: begin
        rd_data_p0 = pc + 32'd4;
        wb_p0      = 1'b1;
        br_p0      = 1'b1;
        pc_sel_p0  = PC_SEL_PCIMM;
      end
      OPC_JALR: begin
        rd_data_p0 = pc + 32'd4;
        wb_p0      = 1'b1;
        br_p0      = 1'b1;
        pc_sel_p0  = PC_SEL_JALR;
      end
      default: ;
    endcase
    // x0 is never written
    if (rd_p0 == 5'd0) wb_p0 = 1'b0;
  end

  // Stage boundary: p0 decode/execute -> registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode   <= '0;
      func3    <= '0;
      wb_reg   <= 1'b0;
      rd_num   <= '0;
      rd_data  <= '0;
      imm      <= '0;
      pc_sel   <= PC_SEL_PLUS4;
      br_taken <= 1'b0;
    end else begin
      opcode   <= opc_p0;
      func3    <= f3_p0;
      wb_reg   <= wb_p0;
      rd_num   <= rd_p0;
      rd_data  <= rd_data_p0;
      imm      <= imm_p0;
      pc_sel   <= pc_sel_p0;
      br_taken <= br_p0;
    end
  end

endmodule

// File: tb/tb_decode_execute.sv
module tb_decode_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_num, rs2_num, rd_num;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        wb_reg, br_taken;
  logic [31:0] rd_data, imm;
  logic [1:0]  pc_sel;

  localparam logic [1:0] SEL_PLUS4 = 2'd0;
  localparam logic [1:0] SEL_PCIMM = 2'd1;
  localparam logic [1:0] SEL_JALR  = 2'd2;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [31:0] rd_data;
    logic        wb;
    logic        br;
    logic [1:0]  sel;
    logic        chk_imm;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];

  decode_execute dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_num  (rs1_num),
    .rs2_num  (rs2_num),
    .opcode   (opcode),
    .func3    (func3),
    .wb_reg   (wb_reg),
    .rd_num   (rd_num),
    .rd_data  (rd_data),
    .imm      (imm),
    .pc_sel   (pc_sel),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drive one instruction mid-cycle, check the combinational read
  // addresses, and queue the result expected after the next edge.
  task automatic issue(input string name, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rd_exp, input logic wb_exp,
                       input logic br_exp, input logic [1:0] sel_exp,
                       input logic chk_imm, input logic [31:0] imm_exp);
    exp_t e;
    @(negedge clk);
    ir = i; rs1_data = a; rs2_data = b;
    #1;
    chk({name, ".rs1_num"}, 32'(rs1_num), 32'(i[19:15]));
    chk({name, ".rs2_num"}, 32'(rs2_num), 32'(i[24:20]));
    e.name = name; e.ir = i; e.rd_data = rd_exp; e.wb = wb_exp; e.br = br_exp;
    e.sel = sel_exp; e.chk_imm = chk_imm; e.imm = imm_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".opcode"},   32'(opcode),   32'(e.ir[6:0]));
    chk({e.name, ".func3"},    32'(func3),    32'(e.ir[14:12]));
    chk({e.name, ".rd_num"},   32'(rd_num),   32'(e.ir[11:7]));
    chk({e.name, ".rd_data"},  rd_data,       e.rd_data);
    chk({e.name, ".wb_reg"},   32'(wb_reg),   32'(e.wb));
    chk({e.name, ".br_taken"}, 32'(br_taken), 32'(e.br));
    chk({e.name, ".pc_sel"},   32'(pc_sel),   32'(e.sel));
    if (e.chk_imm) chk({e.name, ".imm"}, imm, e.imm);
  endtask

  initial begin
    rst_n = 1'b0; ir = 32'h0; pc = 32'h100; rs1_data = 32'd8; rs2_data = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU / immediate group with rs1=8, rs2=3
    issue("add",   32'h002081B3, 32'd8, 32'd3, 32'h0000000B, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("xori",  32'h03F0C113, 32'd8, 32'd3, 32'h00000037, 1'b1, 1'b0, SEL_PLUS4, 1'b1, 32'h3F);
    issue("lw",    32'h02A0A103, 32'd8, 32'd3, 32'h00000032, 1'b1, 1'b0, SEL_PLUS4, 1'b1, 32'h2A);

    // Reset in the middle of a cycle clears outputs without a clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.rd_data",  rd_data,          32'h0);
    chk("rst.wb_reg",   32'(wb_reg),      32'h0);
    chk("rst.rd_num",   32'(rd_num),      32'h0);
    chk("rst.opcode",   32'(opcode),      32'h0);
    chk("rst.func3",    32'(func3),       32'h0);
    chk("rst.imm",      imm,              32'h0);
    chk("rst.pc_sel",   32'(pc_sel),      32'(SEL_PLUS4));
    chk("rst.br_taken", 32'(br_taken),    32'h0);
    chk("rst.rs1_num",  32'(rs1_num),     32'(ir[19:15]));
    @(negedge clk);
    rst_n = 1'b1;

    // Branches
    issue("bne_t",  32'h00209A63, 32'd8, 32'd3, 32'h0, 1'b0, 1'b1, SEL_PCIMM, 1'b1, 32'h14);
    issue("bne_nt", 32'h00209A63, 32'd8, 32'd8, 32'h0, 1'b0, 1'b0, SEL_PLUS4, 1'b1, 32'h14);
    issue("beq_t",  32'h00208A63, 32'd8, 32'd8, 32'h0, 1'b0, 1'b1, SEL_PCIMM, 1'b1, 32'h14);
    // BLT signed: -1 < 3 taken; BLTU unsigned: 0xFFFFFFFF < 3 not taken
    issue("blt_t",  32'h0020CA63, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0, 1'b1, SEL_PCIMM, 1'b0, 32'h0);
    issue("bltu_nt",32'h0020EA63, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("bgeu_t", 32'h0020FA63, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0, 1'b1, SEL_PCIMM, 1'b0, 32'h0);
    // funct3 010 is not a branch condition
    issue("br_f3_2",32'h0020AA63, 32'd8, 32'd3, 32'h0, 1'b0, 1'b0, SEL_PLUS4, 1'b0, 32'h0);

    // Upper immediates and jumps
    issue("lui",   32'hAAAAA0B7, 32'd8, 32'd3, 32'hAAAAA000, 1'b1, 1'b0, SEL_PLUS4, 1'b1, 32'hAAAAA000);
    issue("auipc", 32'hAAAAA097, 32'd8, 32'd3, 32'hAAAAA100, 1'b1, 1'b0, SEL_PLUS4, 1'b1, 32'hAAAAA000);
    issue("jal",   32'h5540016F, 32'd8, 32'd3, 32'h00000104, 1'b1, 1'b1, SEL_PCIMM, 1'b1, 32'h554);
    issue("jalr",  32'hAAA08167, 32'd8, 32'd3, 32'h00000104, 1'b1, 1'b1, SEL_JALR,  1'b1, 32'hFFFFFAAA);

    // Signed boundary cases with rs1=0x80000000, rs2=1
    issue("sub",   32'h402081B3, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("sra",   32'h4020D1B3, 32'h80000000, 32'd1, 32'hC0000000, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("slt",   32'h0020A1B3, 32'h80000000, 32'd1, 32'h00000001, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("sltu",  32'h0020B1B3, 32'h80000000, 32'd1, 32'h00000000, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("srl",   32'h0020D1B3, 32'h80000000, 32'd1, 32'h40000000, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    // SRAI x3,x1,4 and SLLI x3,x1,4 use ir[24:20] as shift amount
    issue("srai",  32'h4040D193, 32'h80000000, 32'd1, 32'hF8000000, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    issue("slli",  32'h00409193, 32'h00000011, 32'd1, 32'h00000110, 1'b1, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    // ADDI with negative immediate: 8 + (-1) = 7
    issue("addi",  32'hFFF08193, 32'd8, 32'd3, 32'h00000007, 1'b1, 1'b0, SEL_PLUS4, 1'b1, 32'hFFFFFFFF);

    // Store: SW x2,0x2A(x1) -> address, no write-back
    issue("sw",    32'h0220A523, 32'd8, 32'd3, 32'h00000032, 1'b0, 1'b0, SEL_PLUS4, 1'b1, 32'h2A);
    // Writes to x0 are suppressed
    issue("add_x0",32'h00208033, 32'd8, 32'd3, 32'h0000000B, 1'b0, 1'b0, SEL_PLUS4, 1'b0, 32'h0);
    // Unknown opcode
    issue("unk",   32'h002081FF, 32'd8, 32'd3, 32'h0, 1'b0, 1'b0, SEL_PLUS4, 1'b1, 32'h0);

    total++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_execute.md
Name: decode_execute

Overview:
- Combined RV32I decode and execute stage of the TinyRisc-V core, located between fetch and memory/writeback.
- Combinationally decodes `ir`, presents register-file read addresses in the same cycle, and evaluates ALU, branch and jump behaviour with the returned operands.
- Registers all results on the next `clk` edge for the downstream PC mux and writeback logic.

Parameters:
- SEL_PC_WIDTH, 2, width of `pc_sel`. Defined in the shared `param_pc_mux.vh`, not overridable per instance.

Ports:
- clk  in  1  core clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- ir  in  32  instruction word
- pc  in  32  address of `ir`
- rs1_data  in  32  register-file value for `rs1_num`, same cycle
- rs2_data  in  32  register-file value for `rs2_num`, same cycle
- rs1_num  out  5  `ir[19:15]`, combinational
- rs2_num  out  5  `ir[24:20]`, combinational
- opcode  out  7  registered `ir[6:0]`
- func3  out  3  registered `ir[14:12]`
- wb_reg  out  1  registered register-file write enable
- rd_num  out  5  registered `ir[11:7]`
- rd_data  out  32  registered result, or effective address for loads/stores
- imm  out  32  registered sign-extended immediate
- pc_sel  out  SEL_PC_WIDTH  registered next-PC select
- br_taken  out  1  registered redirect flag

Behaviour:
- Reset and timing
  - `rst_n` low asynchronously clears every registered output to 0 (`pc_sel` = PC_SEL_PLUS4).
  - `rs1_num` and `rs2_num` are purely combinational and are unaffected by reset.
  - Latency: each registered output reflects the `ir`, `pc` and operands present before the rising edge, one cycle later. There is no handshake; a new instruction is accepted every cycle.
- Immediates, selected by opcode
  - I: `ir[31:20]`
  - S: `{ir[31:25], ir[11:7]}`
  - B: `{ir[31], ir[7], ir[30:25], ir[11:8], 0}`
  - U: `{ir[31:12], 12'b0}`
  - J: `{ir[31], ir[19:12], ir[20], ir[30:21], 0}`
  - I, S, B and J are sign-extended to 32 bits. `imm` = 0 for unknown opcodes.
- OP (0110011), `wb_reg` = 1, funct3 decode:
  - 000: ADD, or SUB when `ir[30]` = 1
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when `ir[30]` = 1
  - 110: OR
  - 111: AND
  - Shift amount is `rs2_data[4:0]`.
- OP-IMM (0010011)
  - Same operations with `imm` in place of `rs2_data`. No SUBI.
  - Shift amount is `ir[24:20]`; SRAI when `ir[30]` = 1.
  - `wb_reg` = 1.
- LOAD (0000011): `rd_data` = `rs1_data` + `imm`; `wb_reg` = 1. The memory stage substitutes the loaded data.
- STORE (0100011): `rd_data` = `rs1_data` + `imm`; `wb_reg` = 0.
- BRANCH (1100011)
  - funct3 conditions: 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned).
  - Condition true: `br_taken` = 1, `pc_sel` = PC_SEL_PCIMM.
  - Otherwise, and for funct3 010/011: `br_taken` = 0, `pc_sel` = PC_SEL_PLUS4.
  - `wb_reg` = 0; `rd_data` = 0.
- LUI (0110111): `rd_data` = `imm`; `wb_reg` = 1.
- AUIPC (0010111): `rd_data` = `pc` + `imm`; `wb_reg` = 1.
- JAL (1101111): `rd_data` = `pc` + 4; `wb_reg` = 1; `br_taken` = 1; `pc_sel` = PC_SEL_PCIMM.
- JALR (1100111): `rd_data` = `pc` + 4; `wb_reg` = 1; `br_taken` = 1; `pc_sel` = PC_SEL_JALR. The PC mux computes the target as (`rs1_data` + `imm`) & ~1.
- Non-control opcodes: `br_taken` = 0, `pc_sel` = PC_SEL_PLUS4.
- Unknown opcode: `wb_reg` = 0, `rd_data` = 0, `br_taken` = 0, `pc_sel` = PC_SEL_PLUS4.
- `wb_reg` is forced to 0 when `rd_num` = 0.
- Arithmetic is modulo 2^32 with no overflow flags.

Decomposition:
- `param_pc_mux.vh` holds SEL_PC_WIDTH and the select codes: PC_SEL_PLUS4 = 0, PC_SEL_PCIMM = 1, PC_SEL_JALR = 2.
- A shared opcode/funct3 constants header holds the RV32I encodings.
- One sub-module, `alu`: op select, a, b → 32-bit result, used by OP and OP-IMM.
- Immediate generation, branch compare and the output registers stay in the top level.

Test Plan (`pc` = 0x100, `rs1_data` = 8, `rs2_data` = 3; values checked one cycle after applying `ir`):
- Reset mid-run → all registered outputs are 0 immediately. ADD x3,x1,x2 (0x002081B3) → `rs1_num` 1, `rs2_num` 2, `wb_reg` 1, `rd_num` 3, `rd_data` 0xB.
- XORI x2,x1,0x3F → `rd_data` 0x37. LW x2,0x2A(x1) → `rd_data` 0x32, `wb_reg` 1.
- BNE x1,x2 with B-imm 0x14 → `imm` 0x14, `br_taken` 1, `pc_sel` PCIMM, `wb_reg` 0.
  - Same with `rs2_data` = 8 → `br_taken` 0, `pc_sel` PLUS4.
- LUI x1,0xAAAAA → `rd_data` 0xAAAAA000. AUIPC x1,0xAAAAA → `rd_data` 0xAAAAA100.
- JAL x2 with J-imm 0x554 → `imm` 0x554, `rd_data` 0x104, `pc_sel` PCIMM, `br_taken` 1.
  - JALR x2,0xAAA(x1) → `imm` 0xFFFFFAAA, `rd_data` 0x104, `pc_sel` JALR.
- SUB/SRA/SLT with `rs1_data` 0x80000000, `rs2_data` 1 → 0x7FFFFFFF, 0xC0000000, 1 respectively.
  - ADD with rd = x0 → `wb_reg` 0.
